// File: rtl/fmap_pingpong_ram.sv
// Two-bank ping-pong feature-map buffer. The producer fills one bank while the
// consumer reads the other. Read data arrives 2 cycles after rd_en, with rvalid.
module fmap_chan_ram #(
  parameter int DW    = 16,
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem0 [DEPTH];
  logic [DW-1:0] mem1 [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      if (wbank) mem1[waddr] <= wdata;
      else       mem0[waddr] <= wdata;
    end
  end

  // raddr comes from the registered stage-1 address, giving a synchronous-read array
  assign rd = rbank ? mem1[raddr] : mem0[raddr];
endmodule

module fmap_pingpong_ram #(
  parameter int CH    = 6,
  parameter int DW    = 16,
  parameter int DEPTH = 784,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    waddr,
  input  logic [CH*DW-1:0] wdata,
  input  logic             wr_done,
  output logic             wr_ready,
  output logic             wr_bank,
  input  logic             rd_en,
  input  logic [AW-1:0]    raddr,
  input  logic             rd_done,
  output logic             rd_ready,
  output logic             rd_bank,
  output logic [CH*DW-1:0] rdata,
  output logic             rvalid
);
  localparam logic [AW:0] LIM = (AW+1)'(DEPTH);

  logic [1:0]       full, full_nxt;
  logic             wb, rb;
  logic             wr_acc, wr_swap, rd_acc, rd_swap;
  logic [AW-1:0]    s1_addr;
  logic             s1_bank, s1_oor;
  logic [1:0]       vld_pipe;
  logic [CH*DW-1:0] rd_all;

  assign wr_ready = !full[wb];
  assign rd_ready = full[rb];
  assign wr_bank  = wb;
  assign rd_bank  = rb;
  assign rvalid   = vld_pipe[1];

  assign wr_acc  = wr_en && wr_ready && ({1'b0, waddr} < LIM);
  assign wr_swap = wr_done && wr_ready;
  assign rd_acc  = rd_en && rd_ready;
  assign rd_swap = rd_done && rd_ready;

  // wb and rb always point at different banks when both swaps fire together
  always_comb begin
    full_nxt = full;
    if (wr_swap) full_nxt[wb] = 1'b1;
    if (rd_swap) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 2'b00;
      wb   <= 1'b0;
      rb   <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_swap) wb <= ~wb;
      if (rd_swap) rb <= ~rb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_addr  <= '0;
      s1_bank  <= 1'b0;
      s1_oor   <= 1'b0;
      vld_pipe <= '0;
      rdata    <= '0;
    end else begin
      vld_pipe <= {vld_pipe[0], rd_acc};
      if (rd_acc) begin
        s1_addr <= raddr;
        s1_bank <= rb;
        s1_oor  <= !({1'b0, raddr} < LIM);
      end
      if (vld_pipe[0]) rdata <= s1_oor ? '0 : rd_all;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    fmap_chan_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ch (
      .clk   (clk),
      .we    (wr_acc),
      .wbank (wb),
      .waddr (waddr),
      .wdata (wdata[g*DW +: DW]),
      .rbank (s1_bank),
      .raddr (s1_addr),
      .rd    (rd_all[g*DW +: DW])
    );
  end
endmodule

// File: tb/tb_fmap_pingpong_ram.sv
// Scoreboard bench: a behavioural model queues expected reads with their due
// cycle; every tick compares handshake outputs and popped read results.
module tb_fmap_pingpong_ram;
  localparam int CH = 6, DW = 16, DEPTH = 784, AW = 10, W = CH*DW;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          wr_en = 1'b0, wr_done = 1'b0, rd_en = 1'b0, rd_done = 1'b0;
  logic [AW-1:0] waddr = '0, raddr = '0;
  logic [W-1:0]  wdata = '0;
  logic          wr_ready, wr_bank, rd_ready, rd_bank, rvalid;
  logic [W-1:0]  rdata;

  fmap_pingpong_ram #(.CH(CH), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .waddr(waddr), .wdata(wdata), .wr_done(wr_done),
    .wr_ready(wr_ready), .wr_bank(wr_bank),
    .rd_en(rd_en), .raddr(raddr), .rd_done(rd_done),
    .rd_ready(rd_ready), .rd_bank(rd_bank),
    .rdata(rdata), .rvalid(rvalid)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] d; int due; } exp_t;
  exp_t         q[$];
  logic [W-1:0] m_mem [2][DEPTH];
  logic [1:0]   m_full = 2'b00;
  logic         m_wb = 1'b0, m_rb = 1'b0;
  int           cyc = 0, n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  function automatic logic [W-1:0] pat0(input int n);
    for (int k = 0; k < CH; k++) pat0[k*DW +: DW] = DW'(32'h100 * k + n);
  endfunction

  function automatic logic [W-1:0] pat1(input int n);
    for (int k = 0; k < CH; k++) pat1[k*DW +: DW] = DW'(32'hA000 + 32'h100 * k + n);
    pat1[3*DW +: DW] = 16'hBEEF;
  endfunction

  // one clock: update the model from the driven inputs, advance, then compare
  task automatic tick();
    logic wrdy, rrdy;
    wrdy = !m_full[m_wb];
    rrdy = m_full[m_rb];
    if (rst_n) begin
      if (rd_en && rrdy)
        q.push_back('{d: (int'(raddr) < DEPTH) ? m_mem[m_rb][raddr] : '0, due: cyc + 2});
      if (wr_en && wrdy && int'(waddr) < DEPTH) m_mem[m_wb][waddr] = wdata;
      if (wr_done && wrdy) begin m_full[m_wb] = 1'b1; m_wb = ~m_wb; end
      if (rd_done && rrdy) begin m_full[m_rb] = 1'b0; m_rb = ~m_rb; end
    end
    @(posedge clk); #1;
    cyc++;
    chk("wr_ready", W'(wr_ready), W'(!m_full[m_wb]));
    chk("rd_ready", W'(rd_ready), W'(m_full[m_rb]));
    chk("wr_bank", W'(wr_bank), W'(m_wb));
    chk("rd_bank", W'(rd_bank), W'(m_rb));
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("rvalid", W'(rvalid), W'(1));
      chk("rdata", rdata, q[0].d);
      void'(q.pop_front());
    end else begin
      chk("rvalid_idle", W'(rvalid), W'(0));
    end
  endtask

  task automatic idle();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
  endtask

  initial begin
    rst_n = 0;
    tick(); tick();
    chk("reset_rdata", rdata, '0);
    rst_n = 1;
    tick();

    // fill bank 0
    for (int n = 0; n < DEPTH; n++) begin
      wr_en = 1; waddr = AW'(n); wdata = pat0(n); tick();
    end
    idle(); wr_done = 1; tick(); idle();
    chk("fill0_wr_bank", W'(wr_bank), W'(1));
    chk("fill0_rd_ready", W'(rd_ready), W'(1));

    // read bank 0 back-to-back while filling bank 1
    for (int n = 0; n < DEPTH; n++) begin
      rd_en = 1; raddr = AW'(n);
      wr_en = 1; waddr = AW'(n); wdata = pat1(n);
      tick();
    end
    idle(); wr_done = 1; tick(); idle();
    chk("both_full_wr_ready", W'(wr_ready), W'(0));
    tick(); tick();

    // blocked write, then a read whose rd_done follows one cycle later
    wr_en = 1; waddr = AW'(5); wdata = {CH{16'hDEAD}}; tick(); idle();
    rd_en = 1; raddr = AW'(10); tick(); idle();
    rd_done = 1; tick(); idle();
    chk("swap_rd_bank", W'(rd_bank), W'(1));
    chk("swap_wr_ready", W'(wr_ready), W'(1));
    foreach (m_full[i]) if (i == 0) chk("model_b1_a5", m_mem[1][5], pat1(5));
    rd_en = 1; raddr = AW'(5);   tick();
    rd_en = 1; raddr = AW'(3);   tick();
    rd_en = 1; raddr = AW'(784); tick();
    rd_en = 1; raddr = AW'(1023); tick();
    idle(); tick(); tick();
    chk("oor_rdata_zero", rdata, '0);

    // refill bank 0 partially, then swap both sides on the same edge
    for (int n = 0; n < 4; n++) begin
      wr_en = 1; waddr = AW'(n); wdata = ~pat0(n); tick();
    end
    idle(); wr_done = 1; rd_done = 1; tick(); idle();
    chk("sim_wr_bank", W'(wr_bank), W'(1));
    chk("sim_rd_bank", W'(rd_bank), W'(0));
    chk("sim_rd_ready", W'(rd_ready), W'(1));
    chk("sim_wr_ready", W'(wr_ready), W'(1));
    for (int n = 0; n < 4; n++) begin
      rd_en = 1; raddr = AW'(n); tick();
    end
    idle(); rd_done = 1; tick(); idle();

    // both empty: reads are refused
    rd_en = 1; raddr = AW'(0); tick(); tick(); idle(); tick(); tick();
    chk("empty_rd_ready", W'(rd_ready), W'(0));

    // reset in the middle of a read burst
    for (int n = 0; n < 8; n++) begin
      wr_en = 1; waddr = AW'(n); wdata = pat1(n + 100); tick();
    end
    idle(); wr_done = 1; tick(); idle();
    for (int n = 0; n < 3; n++) begin
      rd_en = 1; raddr = AW'(n); tick();
    end
    #2 rst_n = 0;
    #1;
    chk("rst_rvalid", W'(rvalid), W'(0));
    chk("rst_rd_ready", W'(rd_ready), W'(0));
    chk("rst_wr_ready", W'(wr_ready), W'(1));
    chk("rst_rdata", rdata, '0);
    m_full = 2'b00; m_wb = 0; m_rb = 0;
    q.delete();
    idle();
    tick(); tick();
    rst_n = 1;
    tick(); tick();
    chk("queue_drained", W'(q.size()), W'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fmap_pingpong_ram.md
Name: fmap_pingpong_ram

Overview:
- Parametrised multi-channel feature-map buffer with two ping-pong banks, placed between a layer's producer (conv/pool writer) and the next layer's consumer.
- Each bank holds CH parallel channels of DEPTH words.
- The producer fills one bank while the consumer reads the other. Bank ownership passes by done/ready handshakes.
- Read latency is a fixed 2 cycles, with a valid strobe. Read-address pipeline registers are reset.

Parameters:
CH, 6, number of parallel channels written/read per access
DW, 16, data width per channel (bits)
DEPTH, 784, words per channel per bank
AW, 10, address width; must satisfy 2**AW >= DEPTH

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  write strobe for the current write bank
waddr  input  AW  write address
wdata  input  CH*DW  packed write data; channel k at [k*DW +: DW]
wr_done  input  1  pulse: current write bank is complete, hand it to reader
wr_ready  output  1  current write bank is free to be written
wr_bank  output  1  index of current write bank
rd_en  input  1  read strobe for the current read bank
raddr  input  AW  read address
rd_done  input  1  pulse: reader finished current read bank, release it
rd_ready  output  1  current read bank holds a complete frame
rd_bank  output  1  index of current read bank
rdata  output  CH*DW  packed read data, registered
rvalid  output  1  rdata valid this cycle

Behaviour:
- Clock and reset: one clock domain (clk); asynchronous active-low reset (rst_n).
- State:
  - full[1:0] flags, write pointer wb, read pointer rb.
  - wr_ready = !full[wb]; rd_ready = full[rb]; wr_bank = wb; rd_bank = rb.
- Reset values: full = 2'b00, wb = 0, rb = 0, rvalid = 0, rdata = 0, read pipeline regs = 0.
  - Outputs after reset: wr_ready = 1, rd_ready = 0.
  - Memory contents are not reset.
- Write:
  - wr_en && wr_ready && waddr < DEPTH: all CH channels of bank wb at waddr take wdata at the clock edge.
  - wr_en with !wr_ready, or with waddr >= DEPTH: ignored, no state change.
- Write handoff:
  - wr_done && wr_ready: full[wb] <= 1 and wb <= ~wb on the same edge.
  - wr_done while !wr_ready: ignored.
  - wr_en and wr_done in the same cycle: the write lands in the old bank, then the swap occurs.
- Read pipeline:
  - Cycle 0: rd_en && rd_ready is accepted. Stage 1 registers raddr, rb and an accept bit.
  - Cycle 1: memory array read.
  - Cycle 2: rdata registered; rvalid = 1 for exactly one cycle per accepted rd_en.
  - Latency is exactly 2 cycles. Back-to-back reads give a throughput of 1 per cycle.
  - Address >= DEPTH: accepted, rdata = 0, rvalid = 1.
  - rd_en with !rd_ready: not accepted, rvalid stays 0, rdata holds its previous value.
  - When rvalid = 0, rdata holds its last value.
- Read handoff:
  - rd_done && rd_ready: full[rb] <= 0 and rb <= ~rb.
  - Reads already in flight complete from the bank captured at stage 1, unaffected by the swap.
  - rd_done while !rd_ready: ignored.
- Simultaneous wr_done and rd_done: both apply on the same edge. They always target different banks, so both flag updates take effect.
- No read/write collision by construction: wb == rb implies both banks empty (read blocked) or both full (write blocked).
- Both banks full: wr_ready = 0 until rd_done. Both empty: rd_ready = 0 until wr_done.
- Reset mid-operation: flags, pointers and pipeline clear immediately and asynchronously. An in-flight read produces no rvalid.
- Storage: each bank/channel is a simple dual-port array mappable to block RAM. Read-address registers feed the array; the output register is separate.

Test Plan:
- Reset → wr_ready = 1, rd_ready = 0, wr_bank = 0, rd_bank = 0, rvalid = 0, rdata = 0.
- Fill bank 0: write waddr = n, channel k = 16'h0100*k + n for n = 0..783, then wr_done.
  - Expect wr_bank = 1 and rd_ready = 1.
  - Read raddr 0..783 back-to-back; expect rvalid starting 2 cycles after the first rd_en, continuous for 784 cycles, with data matching.
- Ping-pong: while bank 0 is read, fill bank 1 with distinct data (channel 3 = 16'hBEEF) and pulse wr_done.
  - Expect wr_ready = 0 (both full).
  - rd_done → rd_bank = 1, wr_ready = 1.
  - Reads now return 16'hBEEF on channel 3.
- Blocking: with both banks full, wr_en at waddr 5 with 16'hDEAD, then drain.
  - Expect address 5 unchanged (no write).
  - rd_en with rd_ready = 0 → no rvalid.
- Simultaneous wr_done and rd_done in the same cycle → both flags update; wb and rb both toggle; full count stays constant.
- Edge cases:
  - Read at raddr = 784 → rdata = 0, rvalid = 1.
  - rd_done issued one cycle after rd_en → that read still returns old-bank data 2 cycles later.
  - rst_n asserted mid-burst → rvalid = 0 immediately, flags cleared.
